// File: rtl/rv32_fetch_pc.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding word
// fetches over req/gnt/rvalid and hands instructions to decode via valid/ready.
module rv32_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rv32_has_new_pc,
  input  logic [31:0] rv32_next_pc_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        rv32_instr_valid,
  output logic [31:0] rv32_instr,
  output logic [31:0] rv32_instr_pc,
  input  logic        rv32_instr_ready,
  output logic        rv32_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        stale_q, stale_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        misalign_q, misalign_d;
  logic        req_q;

  logic consume, buf_free;
  assign consume  = valid_q && rv32_instr_ready;
  assign buf_free = !valid_q || rv32_instr_ready;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    stale_d      = stale_q;
    valid_d      = valid_q && !consume;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    misalign_d   = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = REQ;
          end else if (buf_free) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ipc_d   = req_pc_q;
            state_d = REQ;
          end else begin
            // Buffer still occupied: park the response until decode drains it.
            hold_instr_d = imem_rdata;
            hold_pc_d    = req_pc_q;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          valid_d = 1'b1;
          instr_d = hold_instr_q;
          ipc_d   = hold_pc_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything computed above for this cycle.
    if (rv32_has_new_pc) begin
      fetch_pc_d = {rv32_next_pc_val[31:2], 2'b00};
      valid_d    = 1'b0;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      misalign_d = (rv32_next_pc_val[1:0] != 2'b00);
      unique case (state_q)
        REQ: begin
          state_d = imem_gnt ? WAIT : REQ;
          stale_d = stale_q || imem_gnt;
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = REQ;
            stale_d = 1'b0;
          end else begin
            state_d = WAIT;
            stale_d = 1'b1;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= {RESET_PC[31:2], 2'b00};
      req_pc_q     <= '0;
      stale_q      <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      ipc_q        <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      misalign_q   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      stale_q      <= stale_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      misalign_q   <= misalign_d;
      req_q        <= (state_d == REQ);
    end
  end

  // fetch_pc_q is only advanced on grant, so it is the live request address.
  assign imem_req         = req_q;
  assign imem_addr        = fetch_pc_q;
  assign rv32_instr_valid = valid_q;
  assign rv32_instr       = instr_q;
  assign rv32_instr_pc    = ipc_q;
  assign rv32_misalign    = misalign_q;

endmodule

// File: tb/tb_rv32_fetch_pc.sv
// Bench for rv32_fetch_pc: directed scenarios plus random traffic against an
// address-sequence scoreboard and a latency-randomised instruction memory.
module tb_rv32_fetch_pc;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_pc_i;
  logic [31:0] next_pc_i;
  logic        req;
  logic [31:0] addr;
  logic        gnt_i, rvalid_i;
  logic [31:0] rdata_i;
  logic        valid;
  logic [31:0] instr, ipc;
  logic        ready_i;
  logic        mis;

  rv32_fetch_pc #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .rv32_has_new_pc(new_pc_i), .rv32_next_pc_val(next_pc_i),
    .imem_req(req), .imem_addr(addr), .imem_gnt(gnt_i),
    .imem_rvalid(rvalid_i), .imem_rdata(rdata_i),
    .rv32_instr_valid(valid), .rv32_instr(instr), .rv32_instr_pc(ipc),
    .rv32_instr_ready(ready_i), .rv32_misalign(mis)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model: at most one pending fetch
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_dly;
  // knobs
  int p_gnt, p_ready, p_redir, dmin, dmax;
  int          shot;       // 1 now, 2 on grant, 3 on rvalid, 4 on handshake
  logic [31:0] shot_tgt;
  // reference model
  logic [31:0] exp_pc, exp_fetch;
  bit          exp_mis, redir_prev, req_tgt_v, stab_v, want_first;
  logic [31:0] req_tgt, stab_instr, stab_pc, first_hs_pc, last_gnt_addr;
  int          cyc, n_gnt, n_hs;
  int          gcq[$];
  int          hsq[$];
  logic [31:0] gaq[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    new_pc_i = 1'b0; next_pc_i = '0; gnt_i = 1'b0;
    rvalid_i = 1'b0; rdata_i = '0; ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, RPC);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", ipc, 32'd0);
    chk("rst_misalign", 32'(mis), 32'd0);
    pend = 0; exp_pc = RPC; exp_fetch = RPC; exp_mis = 0;
    redir_prev = 0; req_tgt_v = 0; stab_v = 0; want_first = 0; shot = 0;
    n_gnt = 0; n_hs = 0; cyc = 0; last_gnt_addr = 32'hFFFF_FFFF;
    gcq.delete(); hsq.delete(); gaq.delete();
    rst = 1'b0;
    // this cycle is IDLE with reset released; request appears next cycle
    @(posedge clk); @(negedge clk);
    chk("rel_req", 32'(req), 32'd1);
    chk("rel_addr", addr, RPC);
  endtask

  task automatic step();
    bit hs, fire, rv;
    logic [31:0] tgt;
    tgt = '0;
    chk("misalign", 32'(mis), 32'(exp_mis));
    if (redir_prev) chk("valid_after_redir", 32'(valid), 32'd0);
    if (req_tgt_v) begin
      chk("req_after_redir", 32'(req), 32'd1);
      chk("addr_after_redir", addr, req_tgt);
    end
    if (stab_v) begin
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_instr", instr, stab_instr);
      chk("stall_pc", ipc, stab_pc);
    end
    if (req) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      chk("addr_aligned", 32'(addr[1:0]), 32'd0);
    end

    gnt_i = req && ($urandom_range(99) < p_gnt);
    rv = pend && (pend_dly == 0);
    if (pend && pend_dly > 0) pend_dly--;
    rvalid_i = rv;
    rdata_i  = rv ? mdata(pend_addr) : $urandom;
    ready_i  = ($urandom_range(99) < p_ready);
    hs = valid && ready_i;
    fire = (shot == 1) || (shot == 2 && gnt_i) || (shot == 3 && rv) || (shot == 4 && hs);
    if (fire) begin
      tgt = shot_tgt; shot = 0;
    end else if (p_redir > 0 && $urandom_range(99) < p_redir) begin
      fire = 1; tgt = $urandom;
      if ($urandom_range(1) == 1) tgt[1:0] = 2'b00;
    end
    new_pc_i  = fire;
    next_pc_i = fire ? tgt : $urandom;

    if (hs) begin
      chk("instr_pc", ipc, exp_pc);
      chk("instr_data", instr, mdata(exp_pc));
      if (want_first) begin first_hs_pc = ipc; want_first = 0; end
      exp_pc += 32'd4; n_hs++; hsq.push_back(cyc);
    end
    if (rv) pend = 0;
    if (gnt_i) begin
      chk("gnt_addr", addr, exp_fetch);
      pend = 1; pend_addr = addr; pend_dly = int'($urandom_range(dmax, dmin));
      n_gnt++; gcq.push_back(cyc); gaq.push_back(addr); last_gnt_addr = addr;
    end
    if (fire) begin
      exp_fetch = {tgt[31:2], 2'b00}; exp_pc = exp_fetch; exp_mis = (tgt[1:0] != 2'b00);
      want_first = 1; first_hs_pc = 32'hDEAD_BEEF;
    end else begin
      exp_mis = 0;
      if (gnt_i) exp_fetch += 32'd4;
    end
    redir_prev = fire;
    req_tgt_v  = fire && !pend;
    req_tgt    = exp_fetch;
    stab_v     = valid && !ready_i && !fire;
    stab_instr = instr; stab_pc = ipc;

    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k, g0;
    rst = 1'b1; idle_inputs();
    p_gnt = 100; p_ready = 100; p_redir = 0; dmin = 0; dmax = 0; shot = 0;
    @(negedge clk);

    // sequential fetch, zero-wait memory
    do_reset();
    run(8);
    chk("seq_a0", gaq[0], 32'h100);
    chk("seq_a1", gaq[1], 32'h104);
    chk("seq_a2", gaq[2], 32'h108);
    chk("seq_latency", 32'(hsq[0] - gcq[0]), 32'd2);
    chk("seq_req_gap", 32'(gcq[1] - gcq[0]), 32'd2);
    chk("seq_thru0", 32'(hsq[1] - hsq[0]), 32'd2);
    chk("seq_thru1", 32'(hsq[2] - hsq[1]), 32'd2);

    // backpressure
    p_ready = 0;
    do_reset();
    k = 0;
    while (!valid && k < 20) begin step(); k++; end
    chk("bp_first_valid", 32'(valid), 32'd1);
    g0 = n_gnt;
    run(5);
    chk("bp_one_req", 32'(n_gnt - g0), 32'd1);
    p_ready = 100;
    run(10);
    chk("bp_drain", 32'(n_hs >= 4), 32'd1);

    // redirect with a request in flight
    dmin = 3; dmax = 3;
    do_reset();
    k = 0;
    while (last_gnt_addr != 32'h104 && k < 30) begin step(); k++; end
    chk("inflight_gnt104", last_gnt_addr, 32'h104);
    shot = 1; shot_tgt = 32'h200;
    run(20);
    chk("inflight_first", first_hs_pc, 32'h200);

    // redirect coincident with gnt, then with rvalid, then with a handshake
    dmin = 1; dmax = 1;
    do_reset();
    shot = 2; shot_tgt = 32'h40; run(20);
    chk("gnt_redir_first", first_hs_pc, 32'h40);
    shot = 3; shot_tgt = 32'h40; run(20);
    chk("rv_redir_first", first_hs_pc, 32'h40);
    shot = 4; shot_tgt = 32'h300; run(20);
    chk("hs_redir_first", first_hs_pc, 32'h300);

    // misaligned target and wrap
    shot = 1; shot_tgt = 32'h203;
    step();
    chk("mis_pulse", 32'(mis), 32'd1);
    step();
    chk("mis_clear", 32'(mis), 32'd0);
    run(20);
    chk("mis_first", first_hs_pc, 32'h200);
    shot = 1; shot_tgt = 32'hFFFF_FFFC;
    g0 = n_hs;
    run(20);
    chk("wrap_first", first_hs_pc, 32'hFFFF_FFFC);
    chk("wrap_progress", 32'(n_hs - g0 >= 3), 32'd1);

    // random traffic
    p_gnt = 60; p_ready = 60; p_redir = 5; dmin = 0; dmax = 4;
    do_reset();
    run(3000);
    chk("rand_progress", 32'(n_hs > 100), 32'd1);

    // reset while waiting on memory with a valid instruction held
    p_redir = 0; p_ready = 0; p_gnt = 100; dmin = 3; dmax = 3;
    do_reset();
    k = 0;
    while (!(valid && !req && pend) && k < 30) begin step(); k++; end
    chk("mid_wait_reached", 32'(valid && !req && pend), 32'd1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
